// File: rtl/row_prefetch_pingpong_pkg.sv
// Shared types and helpers for the ping-pong row prefetcher.
package row_prefetch_pingpong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Ceiling log2, never below 1 so degenerate sizes still give a legal width.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/row_prefetch_pingpong_row_buffer_dp.sv
// Two-bank line buffer: word-wide write port, pixel-wide registered read port.
module row_buffer_dp
    import row_prefetch_pingpong_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int PIX_W  = 16,
    parameter int WPR    = 80,
    parameter int PIXELS = 640
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [clog2(WPR):0]      waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     re_i,
    input  logic [clog2(PIXELS):0]   raddr_i,
    output logic [PIX_W-1:0]         rdata_o
);

    localparam int PPW = DATA_W / PIX_W;
    localparam int WAW = clog2(WPR);
    localparam int PAW = clog2(PIXELS);
    localparam int LW  = clog2(PPW);

    logic [DATA_W-1:0] mem [2][WPR];

    logic [PAW-1:0]    pidx;
    logic [WAW-1:0]    widx;
    logic [LW-1:0]     lidx;
    logic              in_rng;
    logic [DATA_W-1:0] word;
    logic [PIX_W-1:0]  pix_d;

    always_comb begin
        pidx   = raddr_i[PAW-1:0];
        widx   = WAW'(pidx / PAW'(PPW));
        lidx   = LW'(pidx % PAW'(PPW));
        in_rng = int'(pidx) < PIXELS;
        word   = in_rng ? mem[raddr_i[PAW]][widx] : '0;
        pix_d  = word[lidx*PIX_W +: PIX_W];
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i[WAW]][waddr_i[WAW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= pix_d;
        end
    end

endmodule

// File: rtl/row_prefetch_pingpong.sv
// Fetches display rows from memory into one bank while the other bank
// is shown; frame_start aborts and restarts, row_start swaps banks.
module row_prefetch_pingpong
    import row_prefetch_pingpong_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int PIX_W     = 16,
    parameter int PIXELS    = 640,
    parameter int ROWS      = 480,
    parameter int ADDR_W    = 27,
    parameter int ADDR_STEP = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic [ADDR_W-1:0]         frame_base,
    input  logic                      row_start,
    output logic                      rd_req,
    output logic [ADDR_W-1:0]         rd_address,
    input  logic                      rd_ack,
    input  logic                      rd_valid,
    input  logic [DATA_W-1:0]         rd_data,
    input  logic                      pix_rd_en,
    input  logic [clog2(PIXELS)-1:0]  pix_addr,
    output logic [PIX_W-1:0]          pix_data,
    output logic                      row_ready,
    output logic                      underrun,
    output logic                      busy
);

    localparam int WPR = PIXELS * PIX_W / DATA_W;
    localparam int CW  = clog2(WPR + 1);
    localparam int WAW = clog2(WPR);
    localparam int RW  = clog2(ROWS + 1);

    state_e            state_q, state_d;
    logic              abort_q, abort_d;
    logic              disp_bank_q, disp_bank_d;
    logic              row_ready_q, row_ready_d;
    logic              underrun_q, underrun_d;
    logic [RW-1:0]     row_idx_q, row_idx_d;
    logic [CW-1:0]     ack_cnt_q, ack_cnt_d;
    logic [CW-1:0]     dat_cnt_q, dat_cnt_d;
    logic [ADDR_W-1:0] rd_address_q, rd_address_d;

    logic ack_hit;
    logic val_hit;
    logic wr_en;
    logic last_ack;
    logic more_rows;

    always_comb begin
        state_d      = state_q;
        abort_d      = abort_q;
        disp_bank_d  = disp_bank_q;
        row_ready_d  = row_ready_q;
        underrun_d   = 1'b0;
        row_idx_d    = row_idx_q;
        ack_cnt_d    = ack_cnt_q;
        dat_cnt_d    = dat_cnt_q;
        rd_address_d = rd_address_q;

        ack_hit   = (state_q == REQ) && rd_ack;
        val_hit   = (state_q != IDLE) && rd_valid;
        // Words landing after an abort (or on the abort edge) are dropped.
        wr_en     = val_hit && !abort_q && !frame_start && !rst;
        last_ack  = ack_hit && (ack_cnt_q == CW'(WPR - 1));
        more_rows = (int'(row_idx_q) + 1) < ROWS;

        if (ack_hit) begin
            ack_cnt_d    = ack_cnt_q + 1'b1;
            rd_address_d = rd_address_q + ADDR_W'(ADDR_STEP);
        end
        if (val_hit) begin
            dat_cnt_d = dat_cnt_q + 1'b1;
        end

        unique case (state_q)
            REQ: begin
                if (last_ack) state_d = DRAIN;
            end
            DRAIN: begin
                if (abort_q) begin
                    if (dat_cnt_d == ack_cnt_q) begin
                        state_d   = REQ;
                        abort_d   = 1'b0;
                        ack_cnt_d = '0;
                        dat_cnt_d = '0;
                    end
                end else if (dat_cnt_d == CW'(WPR)) begin
                    state_d     = IDLE;
                    row_ready_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (frame_start) begin
            rd_address_d = frame_base;
            row_idx_d    = '0;
            disp_bank_d  = 1'b0;
            row_ready_d  = 1'b0;
            if (state_q == IDLE) begin
                state_d   = REQ;
                abort_d   = 1'b0;
                ack_cnt_d = '0;
                dat_cnt_d = '0;
            end else begin
                state_d = DRAIN;
                abort_d = 1'b1;
            end
        end else if (row_start) begin
            if (row_ready_q) begin
                disp_bank_d = ~disp_bank_q;
                row_ready_d = 1'b0;
                row_idx_d   = row_idx_q + 1'b1;
                if (more_rows) begin
                    state_d   = REQ;
                    ack_cnt_d = '0;
                    dat_cnt_d = '0;
                end
            end else if (state_q != IDLE) begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            abort_q      <= 1'b0;
            disp_bank_q  <= 1'b0;
            row_ready_q  <= 1'b0;
            underrun_q   <= 1'b0;
            row_idx_q    <= '0;
            ack_cnt_q    <= '0;
            dat_cnt_q    <= '0;
            rd_address_q <= '0;
        end else begin
            state_q      <= state_d;
            abort_q      <= abort_d;
            disp_bank_q  <= disp_bank_d;
            row_ready_q  <= row_ready_d;
            underrun_q   <= underrun_d;
            row_idx_q    <= row_idx_d;
            ack_cnt_q    <= ack_cnt_d;
            dat_cnt_q    <= dat_cnt_d;
            rd_address_q <= rd_address_d;
        end
    end

    assign rd_req     = (state_q == REQ);
    assign rd_address = rd_address_q;
    assign row_ready  = row_ready_q;
    assign underrun   = underrun_q;
    assign busy       = (state_q != IDLE);

    row_buffer_dp #(
        .DATA_W (DATA_W),
        .PIX_W  (PIX_W),
        .WPR    (WPR),
        .PIXELS (PIXELS)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_en),
        .waddr_i ({~disp_bank_q, dat_cnt_q[WAW-1:0]}),
        .wdata_i (rd_data),
        .re_i    (pix_rd_en),
        .raddr_i ({disp_bank_q, pix_addr}),
        .rdata_o (pix_data)
    );

endmodule

// File: tb/tb_row_prefetch_pingpong.sv
// Directed bench with a memory responder and address/pixel scoreboards.
module tb_row_prefetch_pingpong;

    localparam int WPR    = 80;
    localparam int PPW    = 8;
    localparam int STEP   = 8;
    localparam int PIXELS = 640;

    logic         clk = 1'b0;
    logic         rst, frame_start, row_start, rd_ack, rd_valid, pix_rd_en;
    logic [26:0]  frame_base;
    logic [127:0] rd_data;
    logic [9:0]   pix_addr;
    logic         rd_req, row_ready, underrun, busy;
    logic [26:0]  rd_address;
    logic [15:0]  pix_data;

    always #5 clk = ~clk;

    row_prefetch_pingpong #(
        .DATA_W(128), .PIX_W(16), .PIXELS(640),
        .ROWS(480), .ADDR_W(27), .ADDR_STEP(8)
    ) dut (
        .clk(clk), .rst(rst),
        .frame_start(frame_start), .frame_base(frame_base),
        .row_start(row_start),
        .rd_req(rd_req), .rd_address(rd_address),
        .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .pix_data(pix_data),
        .row_ready(row_ready), .underrun(underrun), .busy(busy)
    );

    int checks = 0, errors = 0, cyc = 0;
    int ack_total = 0, valid_total = 0;
    int acks_left = 1000000000, vdelay = 3;
    bit ack_en = 1'b1, chk_addr = 1'b1;
    logic [26:0] vs [int];
    logic [26:0] exp_addr_q [$];
    logic [15:0] exp_pix_q [$];
    int bdisp;
    logic [26:0] bank_base [2];

    function automatic logic [127:0] data_of(input logic [26:0] a);
        logic [31:0] x;
        x = {5'd0, a};
        return {x ^ 32'hDEAD0000, x + 32'd7, x * 32'd3, ~x};
    endfunction

    function automatic logic [15:0] pix_of(input logic [26:0] base, input int k);
        logic [127:0] w;
        w = data_of(base + 27'((k / PPW) * STEP));
        return w[(k % PPW)*16 +: 16];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (pix_rd_en && exp_pix_q.size() > 0)
            chk("pix_data", pix_data, exp_pix_q.pop_front());
        if (rd_ack) ack_total++;
        frame_start = 0;
        row_start   = 0;
        pix_rd_en   = 0;
        if (vs.exists(cyc + 1)) begin
            rd_valid = 1;
            rd_data  = data_of(vs[cyc + 1]);
            vs.delete(cyc + 1);
            valid_total++;
        end else begin
            rd_valid = 0;
            rd_data  = '0;
        end
        if (ack_en && acks_left > 0 && rd_req === 1'b1) begin
            rd_ack = 1;
            acks_left--;
            vs[cyc + 1 + vdelay] = rd_address;
            if (chk_addr) begin
                if (exp_addr_q.size() > 0)
                    chk("rd_address", rd_address, exp_addr_q.pop_front());
                else
                    chk("unexpected_ack", rd_req, 1'b0);
            end
        end else begin
            rd_ack = 0;
        end
    endtask

    task automatic pix_read(input int k, input logic [26:0] base);
        pix_addr  = 10'(k);
        pix_rd_en = 1;
        exp_pix_q.push_back(pix_of(base, k));
        tick();
    endtask

    task automatic expect_fill(input logic [26:0] base, input int n);
        if (chk_addr)
            for (int i = 0; i < n; i++)
                exp_addr_q.push_back(base + 27'(i * STEP));
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (row_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("ready_timeout", row_ready, 1'b1);
    endtask

    task automatic chk_reset_outs();
        chk("rst_rd_req", rd_req, 1'b0);
        chk("rst_rd_address", rd_address, 27'd0);
        chk("rst_pix_data", pix_data, 16'd0);
        chk("rst_row_ready", row_ready, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_busy", busy, 1'b0);
    endtask

    initial begin
        int a0, v0, n, fills;
        logic [26:0] rb;
        rst = 1; frame_start = 0; row_start = 0; rd_ack = 0;
        rd_valid = 0; rd_data = '0; pix_rd_en = 0; pix_addr = '0;
        frame_base = '0; bdisp = 0;
        bank_base[0] = '0; bank_base[1] = '0;
        repeat (3) tick();
        chk_reset_outs();
        rst = 0;
        tick();

        // first row of a frame
        frame_base = 27'h4B000; frame_start = 1;
        expect_fill(27'h4B000, WPR); bank_base[1] = 27'h4B000; bdisp = 0;
        a0 = ack_total; v0 = valid_total;
        tick();
        chk("busy_fill", busy, 1'b1);
        wait_ready(400);
        chk("acks_row", ack_total - a0, WPR);
        chk("valids_at_ready", valid_total - v0, WPR);
        chk("last_addr", rd_address, 27'h4B280);
        chk("idle_busy", busy, 1'b0);
        chk("idle_rd_req", rd_req, 1'b0);
        chk("addr_q_drained", exp_addr_q.size(), 0);

        // swap and read the full row
        row_start = 1; bdisp = 1;
        expect_fill(27'h4B280, WPR); bank_base[0] = 27'h4B280;
        tick();
        chk("fill2_addr", rd_address, 27'h4B280);
        chk("fill2_busy", busy, 1'b1);
        chk("fill2_ready_clr", row_ready, 1'b0);
        for (int k = 0; k < PIXELS; k++) pix_read(k, bank_base[1]);
        pix_addr = 10'd3;
        tick();
        chk("pix_hold", pix_data, pix_of(bank_base[1], 639));
        wait_ready(400);
        chk("fill2_end_addr", rd_address, 27'h4B500);

        // stalled fill and underrun
        ack_en = 0; row_start = 1; bdisp = 0;
        expect_fill(27'h4B500, WPR); bank_base[1] = 27'h4B500;
        tick();
        repeat (200) tick();
        chk("stall_rd_req", rd_req, 1'b1);
        chk("stall_ready", row_ready, 1'b0);
        chk("stall_underrun", underrun, 1'b0);
        row_start = 1;
        tick();
        chk("underrun_pulse", underrun, 1'b1);
        tick();
        chk("underrun_clear", underrun, 1'b0);
        pix_read(0, bank_base[0]);
        pix_read(123, bank_base[0]);
        pix_read(639, bank_base[0]);
        ack_en = 1;
        wait_ready(400);
        row_start = 1; bdisp = 1;
        expect_fill(27'h4B780, WPR); bank_base[0] = 27'h4B780;
        tick();
        pix_read(5, bank_base[1]);
        pix_read(320, bank_base[1]);
        pix_read(638, bank_base[1]);
        wait_ready(400);

        // frame_start with 10 words outstanding
        vdelay = 10; acks_left = 40; row_start = 1; bdisp = 0;
        expect_fill(27'h4BA00, 40);
        a0 = ack_total;
        tick();
        n = 0;
        while (ack_total - a0 < 40 && n < 200) begin
            tick();
            n++;
        end
        chk("acks_before_abort", ack_total - a0, 40);
        frame_base = 27'h100000; frame_start = 1;
        expect_fill(27'h100000, WPR); bank_base[1] = 27'h100000; bdisp = 0;
        tick();
        acks_left = 1000000000; vdelay = 3;
        chk("abort_rd_req", rd_req, 1'b0);
        chk("abort_busy", busy, 1'b1);
        chk("abort_addr", rd_address, 27'h100000);
        n = 0;
        while (rd_req !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("restart_delay", n, 9);
        wait_ready(400);
        pix_read(0, bank_base[0]);
        pix_read(77, bank_base[0]);
        pix_read(639, bank_base[0]);

        // rest of the frame
        fills = 1;
        for (int r = 1; r < 480; r++) begin
            chk_addr = (r < 3 || r > 477);
            row_start = 1; bdisp ^= 1;
            rb = 27'h100000 + 27'(r * 'h280);
            expect_fill(rb, WPR); bank_base[1 - bdisp] = rb;
            tick();
            if (busy === 1'b1) fills++;
            pix_read((r * 37) % PIXELS, bank_base[bdisp]);
            wait_ready(400);
        end
        chk_addr = 1;
        chk("fill_count", fills, 480);
        chk("frame_end_addr", rd_address, 27'h14B000);
        row_start = 1; bdisp ^= 1;
        tick();
        chk("last_swap_busy", busy, 1'b0);
        chk("last_swap_rd_req", rd_req, 1'b0);
        chk("last_swap_ready", row_ready, 1'b0);
        pix_read(10, bank_base[bdisp]);
        repeat (5) tick();
        chk("eof_no_req", rd_req, 1'b0);
        row_start = 1;
        tick();
        chk("eof_no_underrun", underrun, 1'b0);
        chk("eof_idle", busy, 1'b0);

        // frame_start beats simultaneous row_start
        frame_base = 27'h200000; frame_start = 1; bdisp = 0;
        expect_fill(27'h200000, WPR); bank_base[1] = 27'h200000;
        tick();
        wait_ready(400);
        frame_base = 27'h300000; frame_start = 1; row_start = 1; bdisp = 0;
        expect_fill(27'h300000, WPR); bank_base[1] = 27'h300000;
        tick();
        chk("prio_addr", rd_address, 27'h300000);
        chk("prio_ready", row_ready, 1'b0);
        chk("prio_busy", busy, 1'b1);
        pix_read(9, bank_base[0]);
        wait_ready(400);

        // reset in the middle of DRAIN
        vdelay = 10; row_start = 1; bdisp = 1;
        expect_fill(27'h300280, WPR); bank_base[0] = 27'h300280;
        tick();
        pix_read(100, bank_base[1]);
        n = 0;
        while (rd_req === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_all_acked", rd_req, 1'b0);
        chk("drain_busy", busy, 1'b1);
        rst = 1;
        tick();
        chk_reset_outs();
        rst = 0;
        repeat (15) tick();
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_ready", row_ready, 1'b0);
        chk("post_rst_rd_req", rd_req, 1'b0);
        bdisp = 0;
        pix_read(0, 27'h300280);
        pix_read(100, 27'h300280);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
